// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 memory controller: controller FSM states,
// response-counter states and default timing constants.
package mpmc11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRESET1,
    PRESET2,
    PRESET3,
    ACTIVATE,
    READ,
    WRITE,
    PRECHARGE,
    REFRESH
  } mpmc11_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COLLECT,
    S_DONE,
    S_ERR
  } mpmc11_resp_state_t;

  localparam int MPMC11_RESP_TIMEOUT_DEF = 1023;

endpackage

// File: rtl/mpmc11_resp_burst_cnt_watchdog.sv
// Beat-gap watchdog: counts idle cycles while running, restarts on clear,
// and flags expiry once TIMEOUT_CYCLES idle cycles have already elapsed.
module mpmc11_resp_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  logic [TO_W-1:0] gap_q;

  assign expire = run && (gap_q == TO_W'(TIMEOUT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else if (clear) begin
      gap_q <= '0;
    end else if (!expire) begin
      gap_q <= gap_q + 1'b1;
    end
  end

endmodule

// File: rtl/mpmc11_resp_burst_cnt.sv
// Read-response beat counter: strobes accepted beats into the response
// buffer, signals burst completion and flags surplus or missing beats.
import mpmc11_pkg::*;

module mpmc11_resp_burst_cnt #(
  parameter int TIMEOUT_CYCLES = MPMC11_RESP_TIMEOUT_DEF,
  parameter int TO_W           = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  mpmc11_state_t state,
  input  logic          rw,
  input  logic [7:0]    burst_len,
  input  logic          rd_data_valid,
  output logic          resp_we,
  output logic [7:0]    resp_beat_adr,
  output logic [8:0]    resp_cnt,
  output logic          resp_done,
  output logic          resp_overflow,
  output logic          resp_timeout
);

  mpmc11_resp_state_t fsm_q, fsm_d;
  logic [7:0] len_q, len_d;
  logic [8:0] cnt_d;
  logic [7:0] adr_d;
  logic       we_d, done_d, ovf_d, to_d;
  logic       global_clr, wd_run, wd_clear, wd_expire;

  assign global_clr = (state == IDLE);
  assign wd_run     = !global_clr && ((fsm_q == S_ARMED) || (fsm_q == S_COLLECT));
  assign wd_clear   = !wd_run || rd_data_valid;

  mpmc11_resp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .run   (wd_run),
    .clear (wd_clear),
    .expire(wd_expire)
  );

  // NOTE: every next value defaults to its current value first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fsm_d  = fsm_q;
    len_d  = len_q;
    cnt_d  = resp_cnt;
    adr_d  = resp_beat_adr;
    we_d   = 1'b0;
    done_d = resp_done;
    ovf_d  = resp_overflow;
    to_d   = resp_timeout;
    if (global_clr) begin
      // Controller idle wins over everything, including a coincident beat.
      fsm_d  = S_IDLE;
      cnt_d  = '0;
      adr_d  = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
      to_d   = 1'b0;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (rd_data_valid) ovf_d = 1'b1;
          if ((state == PRESET3) && !rw) begin
            len_d = burst_len;
            fsm_d = S_ARMED;
          end
        end
        S_ARMED, S_COLLECT: begin
          if (rd_data_valid) begin
            we_d  = 1'b1;
            adr_d = resp_cnt[7:0];
            cnt_d = resp_cnt + 9'd1;
            if (resp_cnt == {1'b0, len_q}) begin
              fsm_d  = S_DONE;
              done_d = 1'b1;
            end else begin
              fsm_d = S_COLLECT;
            end
          end else if (wd_expire) begin
            fsm_d = S_ERR;
            to_d  = 1'b1;
          end
        end
        S_DONE: begin
          if (rd_data_valid) ovf_d = 1'b1;
        end
        default: ; // S_ERR: beats ignored until the controller idles
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= S_IDLE;
      len_q         <= '0;
      resp_we       <= 1'b0;
      resp_beat_adr <= '0;
      resp_cnt      <= '0;
      resp_done     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_timeout  <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      len_q         <= len_d;
      resp_we       <= we_d;
      resp_beat_adr <= adr_d;
      resp_cnt      <= cnt_d;
      resp_done     <= done_d;
      resp_overflow <= ovf_d;
      resp_timeout  <= to_d;
    end
  end

endmodule

// File: tb/tb_mpmc11_resp_burst_cnt.sv
// Bench for mpmc11_resp_burst_cnt: directed vector table, hand-written corner
// sequences and random traffic checked against a burst-level reference model.
import mpmc11_pkg::*;

module tb_mpmc11_resp_burst_cnt;

  localparam int T_CYC = 8;

  logic          clk = 1'b0;
  logic          rst;
  mpmc11_state_t state;
  logic          rw;
  logic [7:0]    burst_len;
  logic          rd_data_valid;
  logic          resp_we;
  logic [7:0]    resp_beat_adr;
  logic [8:0]    resp_cnt;
  logic          resp_done, resp_overflow, resp_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mpmc11_resp_burst_cnt #(.TIMEOUT_CYCLES(T_CYC), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .state(state), .rw(rw), .burst_len(burst_len),
    .rd_data_valid(rd_data_valid), .resp_we(resp_we), .resp_beat_adr(resp_beat_adr),
    .resp_cnt(resp_cnt), .resp_done(resp_done), .resp_overflow(resp_overflow),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: a burst is "waiting" for need beats, has got of them,
  // and has seen idle cycles since the last beat; it dies after >T idle cycles.
  typedef enum int {P_NONE, P_WAIT, P_FULL, P_DEAD} phase_t;
  phase_t m_phase;
  int     m_need, m_got, m_idle, m_adr;
  bit     m_we, m_done, m_ovf, m_to;

  function void model_reset();
    m_phase = P_NONE; m_need = 0; m_got = 0; m_idle = 0; m_adr = 0;
    m_we = 0; m_done = 0; m_ovf = 0; m_to = 0;
  endfunction

  function void model_step(mpmc11_state_t st, bit r, int bl, bit v);
    m_we = 0;
    if (st == IDLE) begin
      m_phase = P_NONE; m_got = 0; m_adr = 0; m_done = 0; m_ovf = 0; m_to = 0;
      return;
    end
    case (m_phase)
      P_NONE: begin
        if (v) m_ovf = 1;
        if (st == PRESET3 && !r) begin
          m_phase = P_WAIT; m_need = bl + 1; m_idle = 0;
        end
      end
      P_WAIT: begin
        if (v) begin
          m_we = 1; m_adr = m_got; m_got++; m_idle = 0;
          if (m_got == m_need) begin m_phase = P_FULL; m_done = 1; end
        end else begin
          m_idle++;
          if (m_idle > T_CYC) begin m_phase = P_DEAD; m_to = 1; end
        end
      end
      P_FULL: if (v) m_ovf = 1;
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int we, input int adr, input int cnt,
                            input int done, input int ovf, input int to);
    check({tag, ".we"},   int'(resp_we), we);
    if (we != 0) check({tag, ".adr"}, int'(resp_beat_adr), adr);
    check({tag, ".cnt"},  int'(resp_cnt), cnt);
    check({tag, ".done"}, int'(resp_done), done);
    check({tag, ".ovf"},  int'(resp_overflow), ovf);
    check({tag, ".to"},   int'(resp_timeout), to);
  endtask

  task automatic check_model(input string tag);
    check_outs(tag, int'(m_we), m_adr, m_got, int'(m_done), int'(m_ovf), int'(m_to));
  endtask

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic drive(input mpmc11_state_t st, input bit r, input int bl, input bit v);
    state = st; rw = r; burst_len = 8'(bl); rd_data_valid = v;
    @(posedge clk);
    model_step(st, r, bl, v);
    @(negedge clk);
  endtask

  task automatic drive_chk(input string tag, input mpmc11_state_t st, input bit r,
                           input int bl, input bit v);
    drive(st, r, bl, v);
    check_model(tag);
  endtask

  typedef struct {
    mpmc11_state_t st;
    logic          r;
    logic [7:0]    bl;
    logic          v;
    logic          we;
    logic [7:0]    adr;
    logic [8:0]    cnt;
    logic          done, ovf, to;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int vprob;
    tbl[0]  = '{IDLE,    0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{PRESET3, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{READ,    0, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{READ,    0, 0, 1, 1, 1, 2, 0, 0, 0};
    tbl[4]  = '{READ,    0, 0, 1, 1, 2, 3, 0, 0, 0};
    tbl[5]  = '{READ,    0, 0, 1, 1, 3, 4, 1, 0, 0};
    tbl[6]  = '{READ,    0, 0, 0, 0, 3, 4, 1, 0, 0};
    tbl[7]  = '{IDLE,    0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{WRITE,   1, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{IDLE,    0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{PRESET3, 1, 5, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{WRITE,   1, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{IDLE,    0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{PRESET3, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{READ,    0, 0, 1, 1, 0, 1, 1, 1, 0};
    tbl[15] = '{READ,    0, 0, 1, 0, 0, 1, 1, 1, 0};
    tbl[16] = '{IDLE,    0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{PRESET3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{READ,    0, 0, 1, 1, 0, 1, 1, 0, 0};
    tbl[19] = '{READ,    0, 0, 1, 0, 0, 1, 1, 1, 0};
    tbl[20] = '{PRESET3, 0, 7, 0, 0, 0, 1, 1, 1, 0};
    tbl[21] = '{IDLE,    0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; state = IDLE; rw = 1'b0; burst_len = '0; rd_data_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].r, int'(tbl[i].bl), tbl[i].v);
      check_outs($sformatf("vec%0d", i), int'(tbl[i].we), int'(tbl[i].adr), int'(tbl[i].cnt),
                 int'(tbl[i].done), int'(tbl[i].ovf), int'(tbl[i].to));
    end

    // Gapped burst, beats 5 cycles apart
    drive_chk("gap5", PRESET3, 0, 1, 0);
    drive_chk("gap5", READ, 0, 0, 1);
    repeat (4) drive_chk("gap5", READ, 0, 0, 0);
    drive_chk("gap5", READ, 0, 0, 1);
    check_outs("gap5.end", 1, 1, 2, 1, 0, 0);
    drive_chk("gap5", IDLE, 0, 0, 0);

    // Exactly T idle cycles is still tolerated
    drive_chk("gapT", PRESET3, 0, 1, 0);
    drive_chk("gapT", READ, 0, 0, 1);
    repeat (T_CYC) drive_chk("gapT", READ, 0, 0, 0);
    drive_chk("gapT", READ, 0, 0, 1);
    check_outs("gapT.end", 1, 1, 2, 1, 0, 0);
    drive_chk("gapT", IDLE, 0, 0, 0);

    // T+1 idle cycles times out; the late beat is ignored without overflow
    drive_chk("gap9", PRESET3, 0, 1, 0);
    drive_chk("gap9", READ, 0, 0, 1);
    repeat (T_CYC + 1) drive_chk("gap9", READ, 0, 0, 0);
    check("gap9.to", int'(resp_timeout), 1);
    drive_chk("gap9", READ, 0, 0, 1);
    check_outs("gap9.late", 0, 0, 1, 0, 0, 1);
    drive_chk("gap9", IDLE, 0, 0, 0);
    check_outs("gap9.clr", 0, 0, 0, 0, 0, 0);

    // Maximum burst, back-to-back
    drive_chk("max", PRESET3, 0, 255, 0);
    for (int i = 0; i < 256; i++) begin
      drive(READ, 0, 0, 1);
      check("max.we", int'(resp_we), 1);
      check("max.adr", int'(resp_beat_adr), i);
    end
    check_outs("max.end", 1, 255, 256, 1, 0, 0);
    drive_chk("max", READ, 0, 0, 0);
    drive_chk("max", IDLE, 0, 0, 0);

    // Asynchronous reset mid-burst, off the clock edge
    drive_chk("arst", PRESET3, 0, 3, 0);
    drive_chk("arst", READ, 0, 0, 1);
    drive_chk("arst", READ, 0, 0, 1);
    #2 rst = 1'b1;
    #1 check_outs("arst.now", 0, 0, 0, 0, 0, 0);
    model_reset();
    state = IDLE; rd_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_chk("rearm", PRESET3, 0, 3, 0);
    for (int i = 0; i < 4; i++) drive_chk("rearm", READ, 0, 0, 1);
    check_outs("rearm.end", 1, 3, 4, 1, 0, 0);
    drive_chk("rearm", IDLE, 0, 0, 0);

    // Random traffic against the reference model
    vprob = 50;
    for (int c = 0; c < 3000; c++) begin
      int sel;
      mpmc11_state_t st;
      if (c % 64 == 0) vprob = (c % 192 == 0) ? 90 : ((c % 128 == 0) ? 50 : 8);
      sel = $urandom_range(0, 99);
      st = (sel < 6) ? IDLE : (sel < 18) ? PRESET3 : (sel < 70) ? READ : WRITE;
      drive_chk("rand", st, bit'($urandom_range(0, 3) == 0), $urandom_range(0, 11),
                bit'($urandom_range(0, 99) < vprob));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
